// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame-format constants,
// used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_DONE   = 3'd5
   } uart_state_t;

   localparam bit   C_PARITY_EN   = 1'b1;
   localparam logic C_START_LEVEL = 1'b0;
   localparam logic C_STOP_LEVEL  = 1'b1;
   localparam logic C_IDLE_LEVEL  = 1'b1;

   // The line is occupied from the start bit through the stop bit.
   function automatic logic f_is_busy(input uart_state_t s);
      return (s == S_START) || (s == S_DATA) || (s == S_PARITY) || (s == S_STOP);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while run is high and flags
// the last cycle of each serial bit.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic bit_tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_count;

   // Held at zero whenever the line is idle so every frame starts phase-aligned.
   always_ff @(posedge clk) begin
      if (!rst_n || !run) begin
         r_count <= '0;
      end else if (r_count == LAST) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign bit_tick = run && (r_count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, WIDTH data bits LSB first, optional even
// parity, one stop bit, then a one-cycle done pulse.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = int'(C_PARITY_EN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tx_en,
   input  logic             tx_start,
   input  logic [WIDTH-1:0] tx_data,
   output logic             tx_out,
   output logic             busy,
   output logic             done
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   uart_state_t      r_state, w_state_next;
   logic [WIDTH-1:0] r_shift, w_shift_next;
   logic [BW-1:0]    r_bit_cnt, w_bit_cnt_next;
   logic             r_parity, w_parity_next;
   logic             r_tx_out, w_tx_out_next;
   logic             w_accept;
   logic             w_run;
   logic             w_bit_tick;

   assign w_accept = (r_state == S_IDLE) && tx_en && tx_start;
   assign w_run    = f_is_busy(r_state);

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (w_run),
      .bit_tick(w_bit_tick)
   );

   always_comb begin
      w_state_next   = r_state;
      w_shift_next   = r_shift;
      w_bit_cnt_next = r_bit_cnt;
      w_parity_next  = r_parity;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next   = S_START;
               w_shift_next   = tx_data;
               w_parity_next  = ^tx_data;
               w_bit_cnt_next = '0;
            end
         end
         S_START: begin
            if (w_bit_tick) w_state_next = S_DATA;
         end
         S_DATA: begin
            if (w_bit_tick) begin
               w_shift_next = r_shift >> 1;
               if (r_bit_cnt == LAST_BIT) begin
                  w_bit_cnt_next = '0;
                  w_state_next   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  w_bit_cnt_next = r_bit_cnt + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (w_bit_tick) w_state_next = S_STOP;
         end
         S_STOP: begin
            if (w_bit_tick) w_state_next = S_DONE;
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // The line level is decided from the upcoming state so the registered
   // output changes on the same edge as the state it belongs to.
   always_comb begin
      w_tx_out_next = C_IDLE_LEVEL;
      case (w_state_next)
         S_START:  w_tx_out_next = C_START_LEVEL;
         S_DATA:   w_tx_out_next = w_shift_next[0];
         S_PARITY: w_tx_out_next = w_parity_next;
         S_STOP:   w_tx_out_next = C_STOP_LEVEL;
         default:  w_tx_out_next = C_IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_parity  <= 1'b0;
         r_tx_out  <= C_IDLE_LEVEL;
      end else begin
         r_state   <= w_state_next;
         r_shift   <= w_shift_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_parity  <= w_parity_next;
         r_tx_out  <= w_tx_out_next;
      end
   end

   assign tx_out = r_tx_out;
   assign busy   = f_is_busy(r_state);
   assign done   = (r_state == S_DONE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three instances (defaults, no parity, one clock
// per bit) compared cycle by cycle against a frame-level line model.
module tb_uart_transmitter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n    [3];
   logic       tx_en    [3];
   logic       tx_start [3];
   logic [7:0] tx_data  [3];
   logic       tx_out   [3];
   logic       busy     [3];
   logic       done     [3];

   int cpb [3] = '{4, 4, 1};
   int pen [3] = '{1, 0, 1};

   int n_tests = 0;
   int n_fail  = 0;

   uart_transmitter #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n[0]), .tx_en(tx_en[0]), .tx_start(tx_start[0]),
      .tx_data(tx_data[0]), .tx_out(tx_out[0]), .busy(busy[0]), .done(done[0]));

   uart_transmitter #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n[1]), .tx_en(tx_en[1]), .tx_start(tx_start[1]),
      .tx_data(tx_data[1]), .tx_out(tx_out[1]), .busy(busy[1]), .done(done[1]));

   uart_transmitter #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n[2]), .tx_en(tx_en[2]), .tx_start(tx_start[2]),
      .tx_data(tx_data[2]), .tx_out(tx_out[2]), .busy(busy[2]), .done(done[2]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Serial bit number idx of a frame: start, data LSB first, parity, stop.
   function automatic logic line_bit(input logic [7:0] data, input int p, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return data[idx-1];
      if (idx == 9 && p != 0) return ^data;
      return 1'b1;
   endfunction

   // Issue a frame request and follow it cycle by cycle through DONE.
   // keep leaves tx_start asserted; noise perturbs tx_start/tx_data/tx_en mid-frame.
   task automatic send_check(input int d, input logic [7:0] data, input bit keep, input bit noise);
      int nbits;
      int flen;
      nbits = 10 + pen[d];
      flen  = nbits * cpb[d];
      @(negedge clk);
      check($sformatf("d%0d idle busy", d), busy[d], 0);
      check($sformatf("d%0d idle out", d), tx_out[d], 1);
      check($sformatf("d%0d idle done", d), done[d], 0);
      tx_en[d]    = 1'b1;
      tx_start[d] = 1'b1;
      tx_data[d]  = data;
      @(negedge clk);
      if (!keep) tx_start[d] = 1'b0;
      tx_data[d] = 8'($urandom);
      for (int k = 0; k < flen; k++) begin
         check($sformatf("d%0d %02h c%0d out", d, data, k), tx_out[d], line_bit(data, pen[d], k / cpb[d]));
         check($sformatf("d%0d %02h c%0d busy", d, data, k), busy[d], 1);
         check($sformatf("d%0d %02h c%0d done", d, data, k), done[d], 0);
         if (noise) begin
            tx_start[d] = 1'($urandom_range(0, 1));
            tx_data[d]  = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
            tx_en[d]    = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
      end
      check($sformatf("d%0d %02h done pulse", d, data), done[d], 1);
      check($sformatf("d%0d %02h done busy", d, data), busy[d], 0);
      check($sformatf("d%0d %02h done out", d, data), tx_out[d], 1);
      tx_en[d] = 1'b1;
      if (!keep) tx_start[d] = 1'b0;
   endtask

   initial begin
      int  busy_seen;
      int  done_seen;

      for (int i = 0; i < 3; i++) begin
         rst_n[i]    = 1'b0;
         tx_en[i]    = 1'b1;
         tx_start[i] = 1'b0;
         tx_data[i]  = 8'h00;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("d%0d reset out", i), tx_out[i], 1);
         check($sformatf("d%0d reset busy", i), busy[i], 0);
         check($sformatf("d%0d reset done", i), done[i], 0);
         rst_n[i] = 1'b1;
      end

      // Directed frames
      send_check(0, 8'hA5, 0, 0);
      send_check(0, 8'h01, 0, 0);
      send_check(0, 8'hFF, 0, 0);
      send_check(1, 8'h01, 0, 0);
      send_check(2, 8'hC3, 0, 0);

      // Back-to-back frames with tx_start held high
      send_check(0, 8'h3C, 1, 0);
      send_check(0, 8'h3C, 1, 0);
      send_check(0, 8'h3C, 1, 0);
      tx_start[0] = 1'b0;

      // tx_en low blocks acceptance
      @(negedge clk);
      tx_en[1]    = 1'b0;
      tx_start[1] = 1'b1;
      tx_data[1]  = 8'h77;
      busy_seen   = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy[1] !== 1'b0 || tx_out[1] !== 1'b1) busy_seen++;
      end
      check("d1 tx_en low no frame", busy_seen, 0);
      tx_start[1] = 1'b0;
      tx_en[1]    = 1'b1;

      // Reset during data bit 3
      @(negedge clk);
      tx_start[0] = 1'b1;
      tx_data[0]  = 8'hA5;
      @(negedge clk);
      tx_start[0] = 1'b0;
      repeat (17) @(negedge clk);
      check("d0 pre-reset busy", busy[0], 1);
      check("d0 pre-reset bit3", tx_out[0], line_bit(8'hA5, 1, 4));
      rst_n[0] = 1'b0;
      @(negedge clk);
      check("d0 mid reset out", tx_out[0], 1);
      check("d0 mid reset busy", busy[0], 0);
      check("d0 mid reset done", done[0], 0);
      rst_n[0]  = 1'b1;
      done_seen = 0;
      busy_seen = 0;
      repeat (50) begin
         @(negedge clk);
         if (done[0] === 1'b1) done_seen++;
         if (busy[0] === 1'b1) busy_seen++;
      end
      check("d0 no done after reset", done_seen, 0);
      check("d0 no busy after reset", busy_seen, 0);
      send_check(0, 8'h5A, 0, 0);

      // Randomized frames with mid-frame noise on tx_start/tx_data/tx_en
      for (int n = 0; n < 8; n++) begin
         for (int d = 0; d < 3; d++) begin
            send_check(d, 8'($urandom), 0, 1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
